// File: rtl/proc_pkg.sv
// Shared types and constants for the instruction fetch stage.
package proc_pkg;

    localparam int unsigned PC_W  = 16;
    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_HALT = 5'b00000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DELIVER = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } fetch_state_t;

    // Opcode lives in the top OPC_W bits of the instruction word.
    function automatic logic is_halt(input logic [PC_W-1:0] instr);
        return instr[PC_W-1 -: OPC_W] == OP_HALT;
    endfunction

endpackage

// File: rtl/proc_fetch_if.sv
// Instruction memory read port: one request outstanding, held until ack.
interface proc_fetch_if;
    import proc_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [PC_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/proc_pc_reg.sv
// Program counter with load (priority) and +2 increment, 16-bit wraparound.
module proc_pc_reg
    import proc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next_c
);

    always_comb begin
        pc_next_c = pc;
        if (load) begin
            pc_next_c = load_val;
        end else if (inc) begin
            pc_next_c = PC_W'(pc + PC_W'(2));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next_c;
        end
    end

endmodule

// File: rtl/proc_fetch.sv
// Instruction fetch stage: FETCH/DELIVER/DRAIN/HALT with a single outstanding read.
// Define PC_ALIGN_CHK_EN to trap odd redirect targets (err + halt) instead of clearing bit 0.
module proc_fetch
    import proc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    proc_fetch_if.master    imem,
    output logic [PC_W-1:0] instruction,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc_plus2,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted,
    output logic            err
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc, pc_next_c, redir_tgt_c;
    logic [PC_W-1:0] addr_d, instr_d, pc_plus2_d;
    logic            pc_load, pc_inc;
    logic            req_d, valid_d, halted_d, err_d;
    logic            ack_c, redir_bad_c;

`ifdef PC_ALIGN_CHK_EN
    assign redir_tgt_c = redirect_pc;
    assign redir_bad_c = redirect_pc[0];
`else
    assign redir_tgt_c = {redirect_pc[PC_W-1:1], 1'b0};
    assign redir_bad_c = 1'b0;
`endif

    // The post-reset cycle sits in FETCH with no request out; ignore acks there.
    assign ack_c = imem.imem_req & imem.imem_ack;

    proc_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .inc       (pc_inc),
        .load_val  (redir_tgt_c),
        .pc        (pc),
        .pc_next_c (pc_next_c)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        instr_d    = instruction;
        pc_plus2_d = pc_plus2;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    if (redir_bad_c) begin
                        state_d = HALT;
                    end else if (imem.imem_req && !imem.imem_ack) begin
                        state_d = DRAIN;
                    end
                end else if (ack_c) begin
                    instr_d    = imem.imem_rdata;
                    pc_plus2_d = PC_W'(pc + PC_W'(2));
                    pc_inc     = 1'b1;
                    state_d    = DELIVER;
                end
            end
            DELIVER: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    state_d = redir_bad_c ? HALT : FETCH;
                end else if (!stall) begin
                    state_d = is_halt(instruction) ? HALT : FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_load = 1'b1;
                end
                if (redirect && redir_bad_c) begin
                    state_d = HALT;
                end else if (ack_c) begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
        endcase

        req_d    = (state_d == FETCH) || (state_d == DRAIN);
        valid_d  = (state_d == DELIVER);
        halted_d = (state_d == HALT);
        err_d    = err | (pc_load & redir_bad_c);
        // A drain keeps presenting the abandoned address until it is acknowledged.
        addr_d   = (state_d == DRAIN) ? imem.imem_addr : pc_next_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= FETCH;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= RESET_PC;
            instruction    <= '0;
            pc_plus2       <= '0;
            instr_valid    <= 1'b0;
            halted         <= 1'b0;
            err            <= 1'b0;
        end else begin
            state_q        <= state_d;
            imem.imem_req  <= req_d;
            imem.imem_addr <= addr_d;
            instruction    <= instr_d;
            pc_plus2       <= pc_plus2_d;
            instr_valid    <= valid_d;
            halted         <= halted_d;
            err            <= err_d;
        end
    end

endmodule

// File: doc/proc_fetch.md
PROC_FETCH -- requirements
Module: proc_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the PC loaded at reset.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have output imem_req, 1 bit: instruction memory read request, held until imem_ack.
REQ-005 The block SHALL have output imem_addr, 16 bits: byte address of the request.
REQ-006 The block SHALL have input imem_ack, 1 bit: read data valid this cycle; only meaningful while imem_req=1.
REQ-007 The block SHALL have input imem_rdata, 16 bits: fetched instruction word.
REQ-008 The block SHALL have output instruction, 16 bits: instruction presented to the control stage.
REQ-009 The block SHALL have output instr_valid, 1 bit: instruction is valid.
REQ-010 The block SHALL have output pc_plus2, 16 bits: address of the presented instruction plus 2.
REQ-011 The block SHALL have input stall, 1 bit: downstream not ready; the instruction is consumed when instr_valid=1 and stall=0.
REQ-012 The block SHALL have input redirect, 1 bit: branch/jump taken.
REQ-013 The block SHALL have input redirect_pc, 16 bits: redirect target.
REQ-014 The block SHALL have output halted, 1 bit: HALT fetched and delivered; fetch stopped.
REQ-015 The block SHALL have output err, 1 bit: sticky fetch error.

Function
REQ-016 The FSM SHALL have states FETCH, DELIVER, DRAIN and HALT; one outstanding memory request maximum.
REQ-017 In FETCH: imem_req=1 and imem_addr=pc. On imem_ack: instruction<=imem_rdata, pc_plus2<=pc+2, pc<=pc+2, and next state DELIVER.
REQ-018 Latency SHALL be: ack in cycle N -> instr_valid=1 in cycle N+1.
REQ-019 In DELIVER: instr_valid=1, imem_req=0, and outputs held stable while stall=1. On consumption, next state is FETCH, so imem_req is reasserted the following cycle.
REQ-020 If a consumed instruction has opcode [15:11]=5'b00000 (HALT), the next state SHALL be HALT instead of FETCH.
REQ-021 In HALT: imem_req=0, instr_valid=0, halted=1, and the state is held until reset; redirect is ignored.
REQ-022 Redirect in DELIVER (highest priority over stall and consumption): pc<=redirect_pc, instr_valid=0 next cycle, next state FETCH.
REQ-023 Redirect in FETCH without imem_ack: pc<=redirect_pc, next state DRAIN.
REQ-024 In DRAIN: imem_req and imem_addr are held at the old request until imem_ack; the returned data is discarded and the next state is FETCH.
REQ-025 Redirect in FETCH in the same cycle as imem_ack: data discarded, pc<=redirect_pc, next state FETCH; no DRAIN.
REQ-026 Redirect in DRAIN: pc updates to the newest redirect_pc; the drain continues.
REQ-027 The PC SHALL use 16-bit modulo arithmetic: 16'hFFFE+2 = 16'h0000 with no flag.
REQ-028 instruction and pc_plus2 SHALL change only on capture, so they remain stable throughout stall.

Reset
REQ-029 While rst=0 at an edge: pc<=RESET_PC, state<=FETCH, instruction<=0, pc_plus2<=0, instr_valid<=0, halted<=0, err<=0; imem_req=0 while rst=0 is sampled.
REQ-030 Reset mid-request SHALL abandon the request; an ack arriving in the cycle reset is sampled is ignored.
REQ-031 The first cycle after rst=1 is sampled SHALL drive imem_req=1 with imem_addr=RESET_PC.

Configuration
REQ-032 With PC_ALIGN_CHK_EN defined: a redirect with redirect_pc[0]=1 sets err=1 (sticky until reset) and forces state HALT, with halted=1 next cycle.
REQ-033 Without PC_ALIGN_CHK_EN: redirect_pc[0] is forced to 0 on load, and err is tied to 0.

Structure
REQ-034 Shared package proc_pkg SHALL hold the FSM state enum, the OP_HALT=5'b00000 constant and the PC width (16).
REQ-035 The PC register with load/increment SHALL be sub-module proc_pc_reg; all other logic is inline.

Verification
REQ-036 Reset release, ack after 2 cycles with rdata 16'h4000, stall=0 -> imem_addr 0, then 2, then 4 ...; instr_valid pulses with instruction 16'h4000 and pc_plus2 2, 4, 6.
REQ-037 stall=1 for 3 cycles in DELIVER -> instruction and pc_plus2 constant, imem_req=0; stall drops -> imem_req=1 the next cycle.
REQ-038 Redirect to 16'h0100 while a request is outstanding, ack 2 cycles later -> stale data never shows instr_valid; next imem_addr is 16'h0100.
REQ-039 Redirect and imem_ack in the same cycle -> no instr_valid; the next request is to redirect_pc with no DRAIN cycle.
REQ-040 RESET_PC=16'hFFFE -> the second fetch address is 16'h0000.
REQ-041 Fetch rdata 16'h0000 and consume -> halted=1, imem_req stays 0, and redirect is ignored.
REQ-042 With PC_ALIGN_CHK_EN, redirect_pc 16'h0101 -> err=1 and halted=1 next cycle. Without it, the same stimulus gives next imem_addr 16'h0100 and err=0.
